// File: rtl/mlab_delay_pkg.sv
// Shared constants and parity helpers for the MLAB-based programmable delay line.
package mlab_delay_pkg;

  // Register stages between din and dout beyond the programmed delay D.
  localparam int LAT_FIXED = 2;

  // Upper bound on payload width handled by gen_par; index width matches it.
  localparam int MAX_W  = 256;
  localparam int MAX_IW = 8;

  function automatic int num_par(input int data_width, input int par_group);
    return (data_width + par_group - 1) / par_group;
  endfunction

  // Even parity per PAR_GROUP-bit group; bit g covers data[g*par_group +: par_group].
  function automatic logic [MAX_W-1:0] gen_par(input logic [MAX_W-1:0] data,
                                               input int data_width,
                                               input int par_group);
    logic [MAX_W-1:0] par;
    par = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < data_width) begin
        par[MAX_IW'(i / par_group)] = par[MAX_IW'(i / par_group)] ^ data[MAX_IW'(i)];
      end
    end
    return par;
  endfunction

endpackage

// File: rtl/mlab_dp_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset on contents.
module mlab_dp_ram #(
  parameter int WIDTH      = 22,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  (* ramstyle = "MLAB" *) logic [WIDTH-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mlab_delay_line.sv
// Runtime-programmable delay line with per-group parity written alongside each word
// and checked on read; a fill counter qualifies dout after reset or a delay change.
module mlab_delay_line
  import mlab_delay_pkg::*;
#(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_WIDTH = 5,
  parameter int PAR_GROUP  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [ADDR_WIDTH-1:0] delay,
  input  logic                  inj_err,
  input  logic                  parity_err_in,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  parity_err_out,
  output logic                  err_sticky
);

  localparam int NUM_PAR = num_par(DATA_WIDTH, PAR_GROUP);
  localparam int DEPTH   = 2 ** ADDR_WIDTH;
  localparam int WORD_W  = DATA_WIDTH + NUM_PAR;
  localparam int FCW     = ADDR_WIDTH + 2;
  localparam logic [ADDR_WIDTH-1:0] DMAX = ADDR_WIDTH'(DEPTH - 2);
  localparam logic [FCW-1:0]        FMAX = FCW'(DEPTH + 2);

  logic [DATA_WIDTH-1:0] din_reg;
  logic [ADDR_WIDTH-1:0] delay_reg;
  logic                  inj_err_reg;
  logic [ADDR_WIDTH-1:0] wr_ptr_reg;
  logic [FCW-1:0]        fcnt_reg;
  logic [DATA_WIDTH-1:0] dout_reg;
  logic                  dout_valid_reg;
  logic                  parity_err_reg;
  logic                  err_sticky_reg;

  logic [ADDR_WIDTH-1:0] delay_clamped;
  logic [NUM_PAR-1:0]    wr_par;
  logic [WORD_W-1:0]     wr_word;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [WORD_W-1:0]     rd_word;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [NUM_PAR-1:0]    rd_par;
  logic [NUM_PAR-1:0]    chk_par;
  logic [NUM_PAR-1:0]    grp_err;
  logic                  rd_mismatch;
  logic                  valid_next;
  logic                  parity_err_next;

  // Capping D at DEPTH-2 keeps the read address off the slot being written.
  assign delay_clamped = (delay > DMAX) ? DMAX : delay;

  assign wr_par  = NUM_PAR'(gen_par(MAX_W'(din_reg), DATA_WIDTH, PAR_GROUP))
                 ^ NUM_PAR'(inj_err_reg);
  assign wr_word = {wr_par, din_reg};
  assign wr_en   = ena & ~rst;
  assign rd_addr = wr_ptr_reg - ADDR_WIDTH'(1) - delay_reg;

  mlab_dp_ram #(
    .WIDTH      (WORD_W),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_reg),
    .wdata (wr_word),
    .raddr (rd_addr),
    .rdata (rd_word)
  );

  assign rd_data = rd_word[DATA_WIDTH-1:0];
  assign rd_par  = rd_word[WORD_W-1:DATA_WIDTH];
  assign chk_par = NUM_PAR'(gen_par(MAX_W'(rd_data), DATA_WIDTH, PAR_GROUP));

  for (genvar gi = 0; gi < NUM_PAR; gi++) begin : g_chk
    assign grp_err[gi] = chk_par[gi] ^ rd_par[gi];
  end

  assign rd_mismatch = |grp_err;

  // Stale or never-written words are masked until the pipeline has refilled.
  assign valid_next      = (fcnt_reg >= (FCW'(delay_reg) + FCW'(LAT_FIXED)));
  assign parity_err_next = parity_err_in | (valid_next & rd_mismatch);

  always_ff @(posedge clk) begin
    if (rst) begin
      din_reg        <= '0;
      delay_reg      <= '0;
      inj_err_reg    <= 1'b0;
      wr_ptr_reg     <= '0;
      fcnt_reg       <= '0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      parity_err_reg <= 1'b0;
    end else if (ena) begin
      din_reg        <= din;
      delay_reg      <= delay_clamped;
      inj_err_reg    <= inj_err;
      wr_ptr_reg     <= wr_ptr_reg + ADDR_WIDTH'(1);
      if (delay_clamped != delay_reg) begin
        fcnt_reg <= '0;
      end else if (fcnt_reg != FMAX) begin
        fcnt_reg <= fcnt_reg + FCW'(1);
      end
      dout_reg       <= rd_data;
      dout_valid_reg <= valid_next;
      parity_err_reg <= parity_err_next;
    end
  end

  // Sticky flag ignores ena so software can always clear it; a new error wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky_reg <= 1'b0;
    end else if (parity_err_reg) begin
      err_sticky_reg <= 1'b1;
    end else if (err_clr) begin
      err_sticky_reg <= 1'b0;
    end
  end

  assign dout           = dout_reg;
  assign dout_valid     = dout_valid_reg;
  assign parity_err_out = parity_err_reg;
  assign err_sticky     = err_sticky_reg;

endmodule

// File: tb/tb_mlab_delay_line.sv
// Directed self-checking bench for mlab_delay_line (DATA_WIDTH=20, DEPTH=32).
module tb_mlab_delay_line;

  localparam int DW = 20;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b0;
  logic [DW-1:0] din = '0;
  logic [AW-1:0] delay = '0;
  logic          inj_err = 1'b0;
  logic          parity_err_in = 1'b0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          parity_err_out;
  logic          err_sticky;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  mlab_delay_line #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .PAR_GROUP  (10)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ena            (ena),
    .din            (din),
    .delay          (delay),
    .inj_err        (inj_err),
    .parity_err_in  (parity_err_in),
    .err_clr        (err_clr),
    .dout           (dout),
    .dout_valid     (dout_valid),
    .parity_err_out (parity_err_out),
    .err_sticky     (err_sticky)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ena = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [DW-1:0] din5(input int e);
    if (e == 10 || e == 30) return DW'(20'h5A5A5);
    return DW'(e * 3);
  endfunction

  logic [63:0] ena_pat = 64'hEDB7_6DAF_B5DB_6EF7;
  int          ecnt;

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst dout", 32'(dout), 32'h0);
    chk("rst valid", 32'(dout_valid), 32'h0);
    chk("rst perr", 32'(parity_err_out), 32'h0);
    chk("rst sticky", 32'(err_sticky), 32'h0);

    // D=0 ramp: first word on dout at enabled edge 3
    rst = 1'b0;
    ena = 1'b1;
    delay = AW'(0);
    for (int e = 1; e <= 10; e++) begin
      din = DW'(e);
      tick();
      chk($sformatf("d0 valid e%0d", e), 32'(dout_valid), 32'(e >= 3));
      if (e >= 3) chk($sformatf("d0 dout e%0d", e), 32'(dout), 32'(e - 2));
      chk($sformatf("d0 perr e%0d", e), 32'(parity_err_out), 32'h0);
    end

    // D=29 over several pointer wraps, then D=31 clamped to 30
    do_reset();
    delay = AW'(29);
    for (int e = 1; e <= 200; e++) begin
      din = DW'(e);
      if (e == 121) delay = AW'(31);
      tick();
      if (e <= 31) chk($sformatf("d29 valid e%0d", e), 32'(dout_valid), 32'h0);
      if (e >= 34 && e <= 120) begin
        chk($sformatf("d29 valid e%0d", e), 32'(dout_valid), 32'h1);
        chk($sformatf("d29 dout e%0d", e), 32'(dout), 32'(e - 31));
        if (e % 8 == 0) chk($sformatf("d29 perr e%0d", e), 32'(parity_err_out), 32'h0);
      end
      if (e >= 123 && e <= 150) chk($sformatf("d31 valid e%0d", e), 32'(dout_valid), 32'h0);
      if (e >= 156) begin
        chk($sformatf("d31 valid e%0d", e), 32'(dout_valid), 32'h1);
        chk($sformatf("d31 dout e%0d", e), 32'(dout), 32'(e - 32));
      end
    end

    // D=5 with ena gaps: output tracks enabled edges only
    do_reset();
    delay = AW'(5);
    ecnt = 0;
    for (int i = 0; i < 100; i++) begin
      ena = ena_pat[i[5:0]];
      if (ena) begin
        ecnt++;
        din = DW'(ecnt);
      end else begin
        din = DW'(20'hFFFFF);
      end
      tick();
      if (ecnt <= 6) chk($sformatf("ena valid i%0d", i), 32'(dout_valid), 32'h0);
      if (ecnt >= 9) begin
        chk($sformatf("ena valid i%0d", i), 32'(dout_valid), 32'h1);
        chk($sformatf("ena dout i%0d", i), 32'(dout), 32'(ecnt - 7));
      end
    end
    ena = 1'b1;

    // Delay change 4 -> 10 mid-stream
    do_reset();
    delay = AW'(4);
    for (int e = 1; e <= 80; e++) begin
      din = DW'(e + 1000);
      if (e == 41) delay = AW'(10);
      tick();
      if (e >= 20 && e <= 40) begin
        chk($sformatf("chg valid e%0d", e), 32'(dout_valid), 32'h1);
        chk($sformatf("chg dout e%0d", e), 32'(dout), 32'(e - 6 + 1000));
      end
      if (e == 41) chk("chg valid e41", 32'(dout_valid), 32'h1);
      if (e >= 42 && e <= 53) chk($sformatf("chg valid e%0d", e), 32'(dout_valid), 32'h0);
      if (e >= 54) begin
        chk($sformatf("chg valid e%0d", e), 32'(dout_valid), 32'h1);
        chk($sformatf("chg dout e%0d", e), 32'(dout), 32'(e - 12 + 1000));
        chk($sformatf("chg perr e%0d", e), 32'(parity_err_out), 32'h0);
      end
    end

    // Injected parity error on 0x5A5A5, sticky flag and clear behaviour
    do_reset();
    delay = AW'(3);
    for (int e = 1; e <= 40; e++) begin
      din = din5(e);
      inj_err = (e == 10 || e == 30);
      err_clr = (e == 26 || e == 36);
      tick();
      if (e >= 6) begin
        chk($sformatf("inj dout e%0d", e), 32'(dout), 32'(din5(e - 5)));
        chk($sformatf("inj perr e%0d", e), 32'(parity_err_out), 32'(e == 15 || e == 35));
        chk($sformatf("inj sticky e%0d", e), 32'(err_sticky),
            32'((e >= 16 && e <= 25) || e >= 36));
      end
    end
    inj_err = 1'b0;
    err_clr = 1'b1;
    ena = 1'b0;
    tick();
    chk("clr noena sticky", 32'(err_sticky), 32'h0);
    err_clr = 1'b0;
    ena = 1'b1;

    // Upstream error passes through while dout_valid is low
    do_reset();
    delay = AW'(20);
    tick();
    tick();
    parity_err_in = 1'b1;
    tick();
    chk("pin perr", 32'(parity_err_out), 32'h1);
    chk("pin valid", 32'(dout_valid), 32'h0);
    parity_err_in = 1'b0;
    tick();
    chk("pin perr off", 32'(parity_err_out), 32'h0);
    chk("pin sticky", 32'(err_sticky), 32'h1);

    // Reset mid-stream clears outputs; rst wins over ena
    delay = AW'(0);
    for (int e = 1; e <= 8; e++) begin
      din = DW'(e + 500);
      tick();
    end
    chk("mid dout", 32'(dout), 32'(506));
    chk("mid valid", 32'(dout_valid), 32'h1);
    chk("mid sticky", 32'(err_sticky), 32'h1);
    rst = 1'b1;
    ena = 1'b1;
    din = DW'(20'h12345);
    tick();
    chk("mrst dout", 32'(dout), 32'h0);
    chk("mrst valid", 32'(dout_valid), 32'h0);
    chk("mrst perr", 32'(parity_err_out), 32'h0);
    chk("mrst sticky", 32'(err_sticky), 32'h0);
    rst = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      din = DW'(e + 700);
      tick();
      chk($sformatf("post valid e%0d", e), 32'(dout_valid), 32'(e >= 3));
      if (e >= 3) chk($sformatf("post dout e%0d", e), 32'(dout), 32'(e - 2 + 700));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
